// File: rtl/data_memory_mmio.sv
// MEM-stage data responder: word RAM plus a 16-byte MMIO window (GPIO, cycle counter,
// store counter, sticky error status). Loads are combinational; stores commit on the clock edge.
module data_memory_mmio #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic [31:0] gpio_out,
    output logic        err_irq
);
    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

    localparam logic [1:0] SEL_GPIO   = 2'd0;
    localparam logic [1:0] SEL_CYCLE  = 2'd1;
    localparam logic [1:0] SEL_STCNT  = 2'd2;
    localparam logic [1:0] SEL_STATUS = 2'd3;

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_gpio;
    logic [31:0] r_cycle;
    logic [31:0] r_store_cnt;
    logic [1:0]  r_status;

    logic        w_aligned;
    logic        w_ram_hit;
    logic        w_mmio_hit;
    logic        w_range_err;
    logic [31:0] w_mmio_off;
    logic [1:0]  w_mmio_sel;
    logic [AW-1:0] w_ram_idx;
    logic        w_access;
    logic        w_wr_ok;
    logic        w_ram_we;
    logic        w_ram_commit;
    logic        w_mmio_we;
    logic [1:0]  w_err;
    logic [1:0]  w_w1c;
    logic [31:0] w_rdata;

    // The core's MemRead/MemWrite are per-cycle qualifiers with no back-pressure:
    // every request is accepted in the cycle it is presented.
    assign w_aligned    = (addr[1:0] == 2'b00);
    assign w_ram_hit    = ({1'b0, addr} < RAM_BYTES);
    assign w_mmio_off   = addr - MMIO_BASE;
    assign w_mmio_hit   = (w_mmio_off < 32'd16);
    assign w_mmio_sel   = w_mmio_off[3:2];
    assign w_range_err  = !w_ram_hit && !w_mmio_hit;
    assign w_ram_idx    = addr[AW+1:2];

    assign w_access     = MemRead || MemWrite;
    assign w_wr_ok      = MemWrite && w_aligned;
    assign w_ram_we     = w_wr_ok && w_ram_hit;
    assign w_mmio_we    = w_wr_ok && w_mmio_hit;
    assign w_ram_commit = w_ram_we && rst;

    assign w_err = {w_access && w_range_err, w_access && !w_aligned};
    assign w_w1c = (w_mmio_we && (w_mmio_sel == SEL_STATUS)) ? write_data[1:0] : 2'b00;

    always_comb begin
        w_rdata = 32'd0;
        if (MemRead && w_aligned) begin
            if (w_ram_hit) begin
                w_rdata = r_mem[w_ram_idx];
            end else if (w_mmio_hit) begin
                case (w_mmio_sel)
                    SEL_GPIO:   w_rdata = r_gpio;
                    SEL_CYCLE:  w_rdata = r_cycle;
                    SEL_STCNT:  w_rdata = r_store_cnt;
                    default:    w_rdata = {30'd0, r_status};
                endcase
            end
        end
    end

    assign read_data = w_rdata;
    assign gpio_out  = r_gpio;
    assign err_irq   = |r_status;

    // RAM is never cleared; a store presented while reset is asserted is dropped.
    always_ff @(posedge clk) begin
        if (w_ram_commit) begin
            r_mem[w_ram_idx] <= write_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gpio      <= 32'd0;
            r_cycle     <= 32'd0;
            r_store_cnt <= 32'd0;
            r_status    <= 2'b00;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_mmio_we && (w_mmio_sel == SEL_GPIO)) begin
                r_gpio <= write_data;
            end
            if (w_mmio_we && (w_mmio_sel == SEL_STCNT)) begin
                r_store_cnt <= 32'd0;
            end else if (w_ram_we && (r_store_cnt != 32'hFFFF_FFFF)) begin
                r_store_cnt <= r_store_cnt + 32'd1;
            end
            // A new error on the same bit as a W1C wins.
            r_status <= (r_status & ~w_w1c) | w_err;
        end
    end
endmodule

// File: tb/tb_data_memory_mmio.sv
// Directed bench for data_memory_mmio: one bus operation per cycle, driven at the falling
// edge and checked 1 ns later, against hand-computed expected values.
module tb_data_memory_mmio;
    localparam logic [31:0] BASE   = 32'hFFFF_0000;
    localparam logic [31:0] GPIO   = BASE + 32'h0;
    localparam logic [31:0] CYC    = BASE + 32'h4;
    localparam logic [31:0] STCNT  = BASE + 32'h8;
    localparam logic [31:0] STATUS = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic [31:0] gpio_out;
    logic        err_irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] c0;

    data_memory_mmio #(.DEPTH_WORDS(256), .MMIO_BASE(BASE)) dut (
        .clk        (clk),
        .rst        (rst),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data),
        .gpio_out   (gpio_out),
        .err_irq    (err_irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic bus(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        MemRead    = rd;
        MemWrite   = wr;
        addr       = a;
        write_data = d;
        #1;
    endtask

    initial begin
        rst        = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        addr       = 32'd0;
        write_data = 32'd0;
        #2;
        check_eq("rst_gpio", gpio_out, 32'd0);
        check_eq("rst_irq", {31'd0, err_irq}, 32'd0);
        check_eq("rst_rdata_idle", read_data, 32'd0);
        MemRead = 1'b1;
        addr    = CYC;
        #1;
        check_eq("rst_cycle", read_data, 32'd0);
        MemRead = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        bus(1, 0, CYC, 0);
        check_eq("cycle_1", read_data, 32'd1);
        bus(1, 0, CYC, 0);
        check_eq("cycle_2", read_data, 32'd2);

        bus(0, 1, 32'h10, 32'hDEAD_BEEF);
        bus(1, 0, 32'h10, 0);
        check_eq("ld_10", read_data, 32'hDEAD_BEEF);
        bus(1, 0, STCNT, 0);
        check_eq("stcnt_1", read_data, 32'd1);
        bus(1, 1, 32'h10, 32'h1111_1111);
        check_eq("rw_prewrite", read_data, 32'hDEAD_BEEF);
        bus(1, 0, 32'h10, 0);
        check_eq("rw_postwrite", read_data, 32'h1111_1111);
        bus(1, 0, STCNT, 0);
        check_eq("stcnt_2", read_data, 32'd2);

        bus(0, 1, 32'h12, 32'h55);
        check_eq("irq_before_edge", {31'd0, err_irq}, 32'd0);
        bus(1, 0, 32'h10, 0);
        check_eq("misalign_no_write", read_data, 32'h1111_1111);
        check_eq("irq_mis", {31'd0, err_irq}, 32'd1);
        bus(1, 0, STATUS, 0);
        check_eq("status_mis", read_data, 32'd1);
        bus(0, 1, STATUS, 32'd1);
        bus(1, 0, STATUS, 0);
        check_eq("status_w1c", read_data, 32'd0);
        check_eq("irq_cleared", {31'd0, err_irq}, 32'd0);
        bus(1, 0, STCNT, 0);
        check_eq("stcnt_no_bad", read_data, 32'd2);

        bus(1, 0, 32'h400, 0);
        check_eq("ld_oor", read_data, 32'd0);
        bus(1, 0, STATUS, 0);
        check_eq("status_rng", read_data, 32'd2);
        bus(0, 1, 32'h3FC, 32'h0BAD_F00D);
        bus(1, 0, 32'h3FC, 0);
        check_eq("ld_last_word", read_data, 32'h0BAD_F00D);
        bus(1, 0, BASE + 32'h10, 0);
        check_eq("ld_past_mmio", read_data, 32'd0);
        bus(1, 0, BASE - 32'h4, 0);
        check_eq("ld_below_mmio", read_data, 32'd0);
        bus(0, 1, STATUS, 32'd2);
        bus(1, 0, STATUS, 0);
        check_eq("status_w1c_rng", read_data, 32'd0);
        bus(1, 1, 32'h401, 32'h77);
        check_eq("ld_mis_oor", read_data, 32'd0);
        bus(1, 0, STATUS, 0);
        check_eq("status_both", read_data, 32'd3);
        bus(0, 1, STATUS, 32'd1);
        bus(1, 0, STATUS, 0);
        check_eq("status_w1c_bit0", read_data, 32'd2);
        bus(0, 1, STATUS, 32'd2);
        bus(1, 0, STATUS, 0);
        check_eq("status_w1c_bit1", read_data, 32'd0);

        bus(0, 1, GPIO, 32'hA5);
        check_eq("gpio_before_edge", gpio_out, 32'd0);
        bus(1, 0, GPIO, 0);
        check_eq("gpio_out", gpio_out, 32'hA5);
        check_eq("gpio_rd", read_data, 32'hA5);
        bus(1, 0, CYC, 0);
        c0 = read_data;
        bus(0, 0, 0, 0);
        bus(0, 1, CYC, 32'd0);
        bus(1, 0, CYC, 0);
        check_eq("cycle_delta3", read_data, c0 + 32'd3);
        bus(1, 0, STATUS, 0);
        check_eq("cycle_wr_no_err", read_data, 32'd0);
        bus(1, 0, STCNT, 0);
        check_eq("stcnt_3", read_data, 32'd3);
        bus(0, 1, STCNT, 32'h1234);
        bus(1, 0, STCNT, 0);
        check_eq("stcnt_clear", read_data, 32'd0);
        bus(0, 1, 32'h20, 32'hCAFE_0001);
        bus(0, 1, 32'h21, 32'd0);
        bus(1, 0, STCNT, 0);
        check_eq("stcnt_after_clr", read_data, 32'd1);
        check_eq("irq_pre_rst", {31'd0, err_irq}, 32'd1);
        bus(0, 0, 32'h20, 0);
        check_eq("rd_disabled", read_data, 32'd0);

        bus(0, 1, 32'h20, 32'h1234_5678);
        #2 rst = 1'b0;
        #1;
        check_eq("midrst_gpio", gpio_out, 32'd0);
        check_eq("midrst_irq", {31'd0, err_irq}, 32'd0);
        #3;
        MemWrite = 1'b0;
        MemRead  = 1'b1;
        addr     = CYC;
        #1 check_eq("midrst_cycle", read_data, 32'd0);
        addr = STCNT;
        #1 check_eq("midrst_stcnt", read_data, 32'd0);
        addr = STATUS;
        #1 check_eq("midrst_status", read_data, 32'd0);
        @(negedge clk);
        MemRead = 1'b0;
        rst     = 1'b1;
        bus(1, 0, 32'h20, 0);
        check_eq("ram_kept", read_data, 32'hCAFE_0001);
        bus(1, 0, CYC, 0);
        check_eq("cycle_after_rst", read_data, 32'd2);
        bus(0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
